// File: rtl/linebuffer_ctrl_pkg.sv
// Shared types and default geometry for the linebuffer and its sequencer.
// ST_DRAIN exists only when LINEBUFFER_CTRL_DRAIN_EN is defined.
package linebuffer_pkg;

  localparam int LB_BIT_DEPTH_DEFAULT = 8;
  localparam int LB_COLS_DEFAULT      = 28;
  localparam int LB_BANDS_DEFAULT     = 26;

  localparam int COL_W  = $clog2(LB_COLS_DEFAULT);
  localparam int BAND_W = $clog2(LB_BANDS_DEFAULT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_STREAM = 3'd2,
`ifdef LINEBUFFER_CTRL_DRAIN_EN
    ST_DRAIN  = 3'd3,
`endif
    ST_DONE   = 3'd4
  } lb_state_t;

  // Keeps one-entry counters at a legal 1-bit width.
  function automatic int lb_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/linebuffer_ctrl_if.sv
// Handshake and buffer-strobe bundle between the sequencer, its two streams
// and the 3-row shift array.
interface linebuffer_ctrl_if;
  // A beat moves on any rising edge where valid and ready are both high;
  // valid, once raised, is held with stable data until that edge.
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic lb_wr_en;
  logic lb_shift;

  modport master (
    input  in_valid, out_ready,
    output in_ready, out_valid, lb_wr_en, lb_shift
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, out_valid, lb_wr_en, lb_shift
  );
endinterface

// File: rtl/linebuffer_ctrl_counter.sv
// Modulo-MAX counter with clear, enable and terminal-count flag.
module lb_mod_counter #(
  parameter int MAX = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == LAST);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/linebuffer_ctrl.sv
// Sequencer for the 3-row linebuffer: fill, stream, optional drain.
// Drain of the last band is compiled in with LINEBUFFER_CTRL_DRAIN_EN.
module linebuffer_ctrl
  import linebuffer_pkg::*;
#(
  parameter int BIT_DEPTH = LB_BIT_DEPTH_DEFAULT,
  parameter int COLS      = LB_COLS_DEFAULT,
  parameter int BANDS     = LB_BANDS_DEFAULT,
  localparam int CW       = lb_width(COLS),
  localparam int BW       = lb_width(BANDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  linebuffer_ctrl_if.master lb,
  output logic [CW-1:0]     col_idx,
  output logic [BW-1:0]     band_idx,
  output logic              busy,
  output logic              done,
  output lb_state_t         state_dbg
);
  if (COLS < 2 || BANDS < 1 || BIT_DEPTH < 1) begin : g_cfg_check
    $error("linebuffer_ctrl: COLS must be >= 2, BANDS >= 1, BIT_DEPTH >= 1");
  end

  localparam logic [BW-1:0] LAST_BAND = BW'(BANDS - 1);
`ifdef LINEBUFFER_CTRL_DRAIN_EN
  localparam lb_state_t FRAME_END = ST_DRAIN;
`else
  localparam lb_state_t FRAME_END = ST_DONE;
`endif

  lb_state_t       state_q, state_d;
  logic [BW-1:0]   band_q, band_d;
  logic            col_en, col_clr, col_tc;
  logic            accept;
  logic            in_ready_c, out_valid_c, shift_c, done_c;

  lb_mod_counter #(.MAX(COLS), .W(CW)) u_col_cnt (
    .clk(clk), .rst(rst), .clr_i(col_clr), .en_i(col_en),
    .cnt_o(col_idx), .tc_o(col_tc)
  );

`ifdef LINEBUFFER_CTRL_DRAIN_EN
  logic          drain_en, drain_tc;
  logic [CW-1:0] drain_cnt;

  lb_mod_counter #(.MAX(COLS), .W(CW)) u_drain_cnt (
    .clk(clk), .rst(rst), .clr_i(col_clr), .en_i(drain_en),
    .cnt_o(drain_cnt), .tc_o(drain_tc)
  );
`endif

  always_comb begin
    state_d     = state_q;
    band_d      = band_q;
    col_clr     = 1'b0;
    accept      = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    shift_c     = 1'b0;
    done_c      = 1'b0;
`ifdef LINEBUFFER_CTRL_DRAIN_EN
    drain_en    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          col_clr = 1'b1;
          band_d  = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        in_ready_c = 1'b1;
        accept     = lb.in_valid;
      end
      // Taps hold the oldest column: one fire emits it and writes the new beat.
      ST_STREAM: begin
        in_ready_c  = lb.out_ready;
        out_valid_c = lb.in_valid;
        accept      = lb.in_valid & lb.out_ready;
      end
`ifdef LINEBUFFER_CTRL_DRAIN_EN
      ST_DRAIN: begin
        out_valid_c = 1'b1;
        shift_c     = lb.out_ready;
        drain_en    = lb.out_ready;
        if (lb.out_ready && drain_tc) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept && col_tc) begin
      band_d = band_q + 1'b1;
      if ((state_q == ST_FILL && BANDS > 1) ||
          (state_q == ST_STREAM && band_q != LAST_BAND))
        state_d = ST_STREAM;
      else
        state_d = FRAME_END;
    end
  end

  assign col_en = accept;

  // Handshake outputs are forced low while reset is asserted so no beat moves.
  assign lb.in_ready  = in_ready_c & ~rst;
  assign lb.out_valid = out_valid_c & ~rst;
  assign lb.lb_wr_en  = accept & ~rst;
  assign lb.lb_shift  = shift_c & ~rst;
  assign done         = done_c & ~rst;
  assign busy         = (state_q != ST_IDLE) & ~rst;
  assign band_idx     = band_q;
  assign state_dbg    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      band_q  <= '0;
    end else begin
      state_q <= state_d;
      band_q  <= band_d;
    end
  end
endmodule

// File: tb/tb_linebuffer_ctrl.sv
// Directed bench for linebuffer_ctrl (COLS=4, BANDS=3 and COLS=4, BANDS=1).
module tb_linebuffer_ctrl;
  import linebuffer_pkg::*;

  localparam int COLS  = 4;
  localparam int BANDS = 3;
`ifdef LINEBUFFER_CTRL_DRAIN_EN
  localparam bit DRAIN = 1'b1;
`else
  localparam bit DRAIN = 1'b0;
`endif

  typedef logic [9:0] vec_t;

  logic clk;
  logic rst_a, rst_b, start_a, start_b;
  logic [1:0] col_a, band_a, col_b;
  logic [0:0] band_b;
  logic busy_a, done_a, busy_b, done_b;
  lb_state_t state_a, state_b;

  linebuffer_ctrl_if lba ();
  linebuffer_ctrl_if lbb ();

  linebuffer_ctrl #(.BIT_DEPTH(8), .COLS(COLS), .BANDS(BANDS)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .lb(lba),
    .col_idx(col_a), .band_idx(band_a), .busy(busy_a), .done(done_a),
    .state_dbg(state_a)
  );

  linebuffer_ctrl #(.BIT_DEPTH(8), .COLS(COLS), .BANDS(1)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .lb(lbb),
    .col_idx(col_b), .band_idx(band_b), .busy(busy_b), .done(done_b),
    .state_dbg(state_b)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  vec_t       exp_q[$];
  string      name_q[$];
  logic [7:0] exp_d_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         cur_b  = 1'b0;
  logic [7:0] in_tok = 8'h00;

  // External 3-row shift array stand-in: tokens move in on wr_en, oldest at the tap.
  logic [7:0] tb_buf [0:COLS-1];
  logic [7:0] tap;
  assign tap = tb_buf[COLS-1];

  always @(posedge clk) begin
    if (lba.lb_wr_en) begin
      for (int i = COLS - 1; i > 0; i--) tb_buf[i] <= tb_buf[i-1];
      tb_buf[0] <= in_tok;
    end else if (lba.lb_shift) begin
      for (int i = COLS - 1; i > 0; i--) tb_buf[i] <= tb_buf[i-1];
      tb_buf[0] <= 8'hFF;
    end
  end

  vec_t act_a, act_b;
  assign act_a = {lba.in_ready, lba.out_valid, lba.lb_wr_en, lba.lb_shift,
                  busy_a, done_a, col_a, band_a};
  assign act_b = {lbb.in_ready, lbb.out_valid, lbb.lb_wr_en, lbb.lb_shift,
                  busy_b, done_b, col_b, 1'b0, band_b};

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    vec_t       e, a;
    string      nm;
    logic [7:0] ed;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = cur_b ? act_b : act_a;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s @%0t: got ir,ov,wr,sh,busy,done,col,band=%b expected %b",
                 nm, $time, a, e);
      end
    end
    if (!cur_b && lba.out_valid === 1'b1 && lba.out_ready === 1'b1) begin
      checks++;
      if (exp_d_q.size() == 0) begin
        errors++;
        $display("FAIL out_data @%0t: unexpected output column tap=%0d", $time, tap);
      end else begin
        ed = exp_d_q.pop_front();
        if (tap !== ed) begin
          errors++;
          $display("FAIL out_data @%0t: got %0d expected %0d", $time, tap, ed);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic vec_t mk(input bit ir, ov, wr, sh, bsy, dn, input int col, band);
    return {ir, ov, wr, sh, bsy, dn, 2'(col), 2'(band)};
  endfunction

  task automatic cyc(input bit st, iv, ordy, input vec_t e, input string nm);
    if (cur_b) begin
      start_b = st; lbb.in_valid = iv; lbb.out_ready = ordy;
    end else begin
      start_a = st; lba.in_valid = iv; lba.out_ready = ordy;
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fill_a(input int base);
    for (int c = 0; c < COLS; c++) begin
      in_tok = 8'(base + c);
      cyc(1'b0, 1'b1, 1'b1, mk(1, 0, 1, 0, 1, 0, c, 0), "fill");
    end
  endtask

  task automatic stream_a(input int base, input int band, input int c0, input int c1,
                          input bit st);
    for (int c = c0; c <= c1; c++) begin
      in_tok = 8'(base + band * COLS + c);
      exp_d_q.push_back(8'(base + (band - 1) * COLS + c));
      cyc(st, 1'b1, 1'b1, mk(1, 1, 1, 0, 1, 0, c, band), "stream");
    end
  endtask

  task automatic tail_a(input int base);
    if (DRAIN) begin
      for (int c = 0; c < COLS; c++) begin
        in_tok = 8'hEE;
        exp_d_q.push_back(8'(base + (BANDS - 1) * COLS + c));
        cyc(1'b0, 1'b1, 1'b1, mk(0, 1, 0, 1, 1, 0, 0, BANDS), "drain");
      end
    end
    cyc(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 1, 1, 0, BANDS), "done_pulse");
    cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, BANDS), "idle_after_done");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    lba.in_valid = 1'b0; lba.out_ready = 1'b0;
    lbb.in_valid = 1'b0; lbb.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0), "under_reset");
    rst_a = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0), "reset_idle");

    // Frame 1: continuous flow.
    cyc(1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0), "start1");
    fill_a(16);
    stream_a(16, 1, 0, 3, 1'b0);
    stream_a(16, 2, 0, 3, 1'b0);
    tail_a(16);

    // Frame 2: three cycles of downstream back-pressure at col 2.
    cyc(1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, BANDS), "start2");
    fill_a(64);
    stream_a(64, 1, 0, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      in_tok = 8'(64 + COLS + 2);
      cyc(1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 1, 0, 2, 1), "backpressure");
    end
    stream_a(64, 1, 2, 3, 1'b0);
    stream_a(64, 2, 0, 3, 1'b0);
    tail_a(64);

    // Frame 3: upstream bubbles during fill, then reset mid-stream.
    cyc(1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, BANDS), "start3");
    for (int k = 0; k < 2 * COLS; k++) begin
      in_tok = 8'(112 + k / 2);
      cyc(1'b0, 1'(k % 2), 1'b1, mk(1, 0, k % 2, 0, 1, 0, k / 2, 0), "bubble_fill");
    end
    stream_a(112, 1, 0, 1, 1'b0);
    rst_a = 1'b1;
    lba.in_valid = 1'b1; lba.out_ready = 1'b1; in_tok = 8'h77;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0), "post_reset_idle");

    // Frame 4: refill after reset, start held high while busy.
    cyc(1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0), "start4");
    for (int c = 0; c < COLS; c++) begin
      in_tok = 8'(160 + c);
      cyc(1'b1, 1'b1, 1'b1, mk(1, 0, 1, 0, 1, 0, c, 0), "refill");
    end
    stream_a(160, 1, 0, 3, 1'b1);
    stream_a(160, 2, 0, 3, 1'b0);
    tail_a(160);

    // Single-band instance: no STREAM, start ignored while busy and at DONE.
    lba.in_valid = 1'b0; lba.out_ready = 1'b0; start_a = 1'b0;
    cur_b = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0), "b_under_reset");
    rst_b = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0), "b_idle");
    cyc(1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0), "b_start");
    for (int c = 0; c < COLS; c++)
      cyc(1'b1, 1'b1, 1'b1, mk(1, 0, 1, 0, 1, 0, c, 0), "b_fill");
    if (DRAIN) begin
      for (int c = 0; c < COLS; c++)
        cyc(1'b1, 1'b1, 1'b1, mk(0, 1, 0, 1, 1, 0, 0, 1), "b_drain");
    end
    cyc(1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 1, 1, 0, 1), "b_done");
    cyc(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 1), "b_idle_after_done");
    cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1), "b_stays_idle");

    @(posedge clk);
    checks++;
    if (exp_d_q.size() != 0) begin
      errors++;
      $display("FAIL out_count: %0d expected columns never emitted, required 0",
               exp_d_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required stimulus to complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/linebuffer_ctrl.md
# linebuffer_ctrl

Sequencer for the 3-row `linebuffer` shift array feeding the convolution datapath. It accepts a column-serial stream of 3-row pixel beats from the feature-map fetch logic using a valid/ready handshake. It generates the buffer's `wr_en` and `shift` strobes, tracks column and band position, and applies downstream back-pressure. It presents the buffer's tap outputs as a valid/ready stream to the MAC array.

## Interface
- `BIT_DEPTH`, 8: pixel width. Used only for width checks; the controller carries no pixel data.
- `COLS`, 28: columns per band. Must match the buffer's `COLS`. Minimum 2.
- `BANDS`, 26: 3-row bands per frame. Minimum 1.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begins a frame; sampled only in IDLE.
- `in_valid`  in  1  upstream beat available (rows r1..r3 of one column).
- `in_ready`  out  1  controller accepts the beat this cycle.
- `out_valid`  out  1  buffer taps `rd_data_r1..r3` hold a valid column.
- `out_ready`  in  1  downstream consumes the tap column this cycle.
- `lb_wr_en`  out  1  to buffer `wr_en`: an input beat is written at this edge.
- `lb_shift`  out  1  to buffer `shift`: shift without new data (drain).
- `col_idx`  out  clog2(COLS)  column of the current input beat.
- `band_idx`  out  clog2(BANDS+1)  band of the current input beat.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, FILL, STREAM, DRAIN (present only with the macro), DONE.
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 clears both counters and moves to FILL.
- FILL:
  - `in_ready`=1, `out_valid`=0.
  - On accept (`in_valid`&`in_ready`), `lb_wr_en`=1 and `col_idx` increments.
  - On the accept at `col_idx`=COLS-1: `col_idx` wraps to 0 and `band_idx` increments.
  - After that accept, go to STREAM if BANDS>1; otherwise go to DRAIN or DONE.
- STREAM:
  - Buffer is full, so its taps hold the oldest column.
  - `in_ready`=`out_ready` and `out_valid`=`in_valid`.
  - Fire = `in_valid`&`out_ready`. One fire both consumes the tap column and writes the new beat (`lb_wr_en`=1) on the same edge.
  - Counters advance as in FILL.
  - On the fire at `col_idx`=COLS-1 with `band_idx`=BANDS-1, go to DRAIN, or to DONE if the macro is absent.
- DRAIN:
  - `in_ready`=0, `out_valid`=1, `lb_shift`=`out_ready`.
  - An internal drain counter counts COLS shifts, then the state moves to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Output counts per frame:
  - Inputs: BANDS×COLS.
  - Outputs: BANDS×COLS with drain; (BANDS-1)×COLS without drain.
- `lb_wr_en` and `lb_shift` are never high in the same cycle.
- `start` outside IDLE is ignored.
- A `start` that arrives in the same cycle as DONE is not captured.

## Timing
- `lb_wr_en`, `lb_shift`, `in_ready` and `out_valid` are combinational from the state and the handshake inputs. The buffer updates at the same edge as the accept.
- Latency from the first accepted beat to the first `out_valid`-capable cycle is COLS accepts.
- `out_valid` (STREAM) depends combinationally on `in_valid`. Downstream must not make `out_ready` depend on `out_valid`.
- Stalls: `in_valid`=0 or `out_ready`=0 holds the counters and buffer contents and generates no strobes.
- Reset state: IDLE, all counters 0.
- Output values under reset: `in_ready`, `out_valid`, `lb_wr_en`, `lb_shift`, `busy` and `done` are 0; `col_idx` and `band_idx` are 0.
- Reset mid-frame:
  - Returns to IDLE on the next edge and drops any in-flight beat.
  - Buffer contents are not cleared; the next FILL overwrites them.

## Configuration
- `LINEBUFFER_CTRL_DRAIN_EN`, defined:
  - The DRAIN state and drain counter are compiled in.
  - The last band is flushed with COLS `lb_shift` strobes.
- Undefined:
  - No DRAIN state, and `lb_shift` is tied to 0.
  - The last band stays in the buffer unemitted; the frame ends after the final input beat.

## Structure
- Package `linebuffer_pkg`:
  - State enum `lb_state_t`.
  - Width constants `COL_W = clog2(COLS)` and `BAND_W = clog2(BANDS+1)`.
  - Default `COLS`/`BANDS` values shared with `linebuffer`.
- Sub-module `lb_mod_counter`: enable, clear, wrap at MAX-1, terminal-count flag. It is instantiated for the column and drain counters.
- The band counter is a plain increment.

## Test plan
- COLS=4, BANDS=3, `in_valid`=1 and `out_ready`=1 constant:
  - 4 FILL cycles with `lb_wr_en`, then 8 STREAM fires.
  - With drain: 4 `lb_shift` cycles and `done` at cycle 17; 12 outputs total.
- Same setup without the macro: `done` at cycle 13, 8 outputs, `lb_shift` never high.
- Back-pressure: in STREAM, drop `out_ready` for 3 cycles.
  - `in_ready`=0, no `lb_wr_en`, `col_idx` frozen.
  - Data order is preserved after release.
- Upstream bubbles: in FILL, toggle `in_valid` every other cycle. FILL takes 8 cycles and `col_idx` steps 0→3.
- Reset at STREAM `col_idx`=2: the next cycle is IDLE with all outputs 0. A new `start` refills from `col_idx`=0.
- BANDS=1: FILL goes directly to DRAIN, or to DONE without the macro. There is no STREAM cycle, and `start` during `busy` is ignored.
